dmem_responder: RTL and testbench

- Data-memory responder that services load/store requests issued by the core's MEM stage over a valid/ready request channel and a valid/ready response channel.
- Holds the data RAM and applies byte, half and word store masking.
- Performs load sign- or zero-extension and inserts a parameterised number of wait states.
- Flags misaligned, invalid-type and out-of-range accesses with an error response instead of touching memory.

---
 rtl/dmem_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the core's MEM stage. A load/store request is
//   accepted over a valid/ready channel, held for WAIT_STATES cycles, then
//   committed against the internal RAM. The result comes back on a valid/ready
//   response channel. Misaligned, invalid-type and out-of-range accesses
//   return rsp_err=1 and leave the RAM untouched.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request latched, wait-state counter running down to 0
//   RESP  | response presented, held until rsp_ready
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   req_valid      request present
//   req_ready      responder can accept a request
//   req_write      1 = store, 0 = load
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   req_store_type 00 SB, 01 SH, 10 SW, 11 invalid
//   req_load_type  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others invalid
//   rsp_valid      response present
//   rsp_ready      requester accepts response
//   rsp_rdata      extended load data, 0 for stores and errors
//   rsp_err        access fault
//   busy           high whenever not in IDLE

module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_store_type,
    input  logic [2:0]  req_load_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        commit;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_store_type;
    logic [2:0]  lat_load_type;
    logic [3:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Access operands: with zero wait states the commit happens on the
    // acceptance edge, so the live request is used instead of the latch.
    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_store_type;
    logic [2:0]  a_load_type;

    logic [29:0]      off_word;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             fmt_err;
    logic             acc_err;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      ld_data;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             mem_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != S_IDLE);
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit    = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        if (state == S_IDLE) begin
            a_write      = req_write;
            a_addr       = req_addr;
            a_wdata      = req_wdata;
            a_store_type = req_store_type;
            a_load_type  = req_load_type;
        end else begin
            a_write      = lat_write;
            a_addr       = lat_addr;
            a_wdata      = lat_wdata;
            a_store_type = lat_store_type;
            a_load_type  = lat_load_type;
        end
    end

    // ADDR_BASE is word aligned, so the word offset is exact.
    assign off_word = a_addr[31:2] - ADDR_BASE[31:2];
    assign in_range = (a_addr >= ADDR_BASE) && ({2'b00, off_word} < 32'(DEPTH_WORDS));
    assign idx      = off_word[IDX_W-1:0];

    always_comb begin
        fmt_err = 1'b0;
        if (a_write) begin
            case (a_store_type)
                2'b00:   fmt_err = 1'b0;
                2'b01:   fmt_err = a_addr[0];
                2'b10:   fmt_err = (a_addr[1:0] != 2'b00);
                default: fmt_err = 1'b1;
            endcase
        end else begin
            case (a_load_type)
                3'b000, 3'b100: fmt_err = 1'b0;
                3'b001, 3'b101: fmt_err = a_addr[0];
                3'b010:         fmt_err = (a_addr[1:0] != 2'b00);
                default:        fmt_err = 1'b1;
            endcase
        end
    end

    assign acc_err = !in_range || fmt_err;

    assign rd_word = mem[idx];
    assign rd_byte = 8'(rd_word >> {a_addr[1:0], 3'b000});
    assign rd_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = 32'd0;
        case (a_load_type)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick
    // which lanes change.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = a_wdata;
        case (a_store_type)
            2'b00: begin
                wr_be   = 4'b0001 << a_addr[1:0];
                wr_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = a_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = a_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = a_wdata;
            end
        endcase
    end

    assign mem_we = commit && a_write && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_write      <= 1'b0;
            lat_addr       <= 32'd0;
            lat_wdata      <= 32'd0;
            lat_store_type <= 2'd0;
            lat_load_type  <= 3'd0;
            cnt            <= 4'd0;
            rdata_q        <= 32'd0;
            err_q          <= 1'b0;
        end else begin
            if (accept) begin
                lat_write      <= req_write;
                lat_addr       <= req_addr;
                lat_wdata      <= req_wdata;
                lat_store_type <= req_store_type;
                lat_load_type  <= req_load_type;
                cnt            <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= (acc_err || a_write) ? 32'd0 : ld_data;
                err_q   <= acc_err;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 0 runs with two wait states and
// base 0, instance 1 with zero wait states, base 0x1000 and 16 words.
module tb_dmem_responder;

    localparam logic [1:0] ST_SB = 2'b00, ST_SH = 2'b01, ST_SW = 2'b10, ST_BAD = 2'b11;
    localparam logic [2:0] LT_LB = 3'b000, LT_LH = 3'b001, LT_LW = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100, LT_LHU = 3'b101;

    logic        clk;
    logic        rst;
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_write      [2];
    logic [31:0] req_addr       [2];
    logic [31:0] req_wdata      [2];
    logic [1:0]  req_store_type [2];
    logic [2:0]  req_load_type  [2];
    logic        rsp_valid      [2];
    logic        rsp_ready      [2];
    logic [31:0] rsp_rdata      [2];
    logic        rsp_err        [2];
    logic        busy           [2];

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc [2];

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .ADDR_BASE(32'h0000_0000)) dut_ws2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_store_type(req_store_type[0]), .req_load_type(req_load_type[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .ADDR_BASE(32'h0000_1000)) dut_ws0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_store_type(req_store_type[1]), .req_load_type(req_load_type[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] st, input logic [2:0] lt);
        req_write[d]      = wr;
        req_addr[d]       = a;
        req_wdata[d]      = wd;
        req_store_type[d] = st;
        req_load_type[d]  = lt;
        req_valid[d]      = 1'b1;
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge with
    // the request inputs scrambled so late changes would show up as errors.
    task automatic send(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] st, input logic [2:0] lt);
        int n;
        set_req(d, wr, a, wd, st, lt);
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc[d]        = cyc;
        req_valid[d]      = 1'b0;
        req_write[d]      = ~wr;
        req_addr[d]       = ~a;
        req_wdata[d]      = ~wd;
        req_store_type[d] = ~st;
        req_load_type[d]  = ~lt;
    endtask

    // lat = number of edges after acceptance up to the first edge that sees
    // rsp_valid high. Passes the handshake edge when rsp_ready is high.
    task automatic recv(input int d, output logic [31:0] rd, output logic e, output int lat);
        lat = 1;
        while (!rsp_valid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) check("rsp_valid_timeout", 32'(rsp_valid[d]), 32'd1);
        rd = rsp_rdata[d];
        e  = rsp_err[d];
        if (rsp_ready[d]) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input string tag, input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] st, input logic [2:0] lt,
                        input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        int          lat;
        send(d, wr, a, wd, st, lt);
        recv(d, rd, e, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          acc_first;

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]      = 1'b0;
            req_write[d]      = 1'b0;
            req_addr[d]       = 32'd0;
            req_wdata[d]      = 32'd0;
            req_store_type[d] = 2'd0;
            req_load_type[d]  = 3'd0;
            rsp_ready[d]      = 1'b1;
        end

        #2;
        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_rdata", rsp_rdata[0], 32'd0);
        check("rst_err", 32'(rsp_err[0]), 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Store then load, two wait states
        send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, ST_SW, LT_LW);
        check("sw_busy", 32'(busy[0]), 32'd1);
        check("sw_req_ready", 32'(req_ready[0]), 32'd0);
        recv(0, rd, e, lat);
        check("sw_latency", 32'(lat), 32'd3);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", 32'(e), 32'd0);
        xfer("lw10_a", 0, 1'b0, 32'h10, 32'h0, ST_SW, LT_LW, 32'hDEAD_BEEF, 1'b0);

        // Sub-word stores and load extension
        xfer("sb11", 0, 1'b1, 32'h11, 32'hFFFF_FF7F, ST_SB, LT_LW, 32'd0, 1'b0);
        xfer("sh12", 0, 1'b1, 32'h12, 32'h1234_8001, ST_SH, LT_LW, 32'd0, 1'b0);
        xfer("lw10_b", 0, 1'b0, 32'h10, 32'h0, ST_SW, LT_LW, 32'h8001_7FEF, 1'b0);
        xfer("lb13", 0, 1'b0, 32'h13, 32'h0, ST_SW, LT_LB, 32'hFFFF_FF80, 1'b0);
        xfer("lbu13", 0, 1'b0, 32'h13, 32'h0, ST_SW, LT_LBU, 32'h0000_0080, 1'b0);
        xfer("lh12", 0, 1'b0, 32'h12, 32'h0, ST_SW, LT_LH, 32'hFFFF_8001, 1'b0);
        xfer("lhu12", 0, 1'b0, 32'h12, 32'h0, ST_SW, LT_LHU, 32'h0000_8001, 1'b0);
        xfer("lb11", 0, 1'b0, 32'h11, 32'h0, ST_SW, LT_LB, 32'h0000_007F, 1'b0);
        xfer("lhu10", 0, 1'b0, 32'h10, 32'h0, ST_SW, LT_LHU, 32'h0000_7FEF, 1'b0);

        // Faults
        xfer("sw20", 0, 1'b1, 32'h20, 32'hCAFE_F00D, ST_SW, LT_LW, 32'd0, 1'b0);
        xfer("lw12_misal", 0, 1'b0, 32'h12, 32'h0, ST_SW, LT_LW, 32'd0, 1'b1);
        xfer("sh21_misal", 0, 1'b1, 32'h21, 32'h0000_5555, ST_SH, LT_LW, 32'd0, 1'b1);
        xfer("lw20_kept", 0, 1'b0, 32'h20, 32'h0, ST_SW, LT_LW, 32'hCAFE_F00D, 1'b0);
        xfer("lt011", 0, 1'b0, 32'h10, 32'h0, ST_SW, 3'b011, 32'd0, 1'b1);
        xfer("lw_oor", 0, 1'b0, 32'h100, 32'h0, ST_SW, LT_LW, 32'd0, 1'b1);
        xfer("sw_last", 0, 1'b1, 32'hFC, 32'h0BAD_CAFE, ST_SW, LT_LW, 32'd0, 1'b0);
        xfer("lw_last", 0, 1'b0, 32'hFC, 32'h0, ST_SW, LT_LW, 32'h0BAD_CAFE, 1'b0);
        xfer("st_bad", 0, 1'b1, 32'h30, 32'h9999_9999, ST_BAD, LT_LW, 32'd0, 1'b1);
        xfer("sw30_lt_ign", 0, 1'b1, 32'h30, 32'h0102_0304, ST_SW, 3'b111, 32'd0, 1'b0);
        xfer("lw30_st_ign", 0, 1'b0, 32'h30, 32'h0, ST_BAD, LT_LW, 32'h0102_0304, 1'b0);

        // Backpressure in RESP
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 32'h10, 32'h0, ST_SW, LT_LW);
        recv(0, rd, e, lat);
        check("bp_first_rdata", rd, 32'h8001_7FEF);
        set_req(0, 1'b0, 32'h13, 32'h0, ST_SW, LT_LBU);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rdata_hold", rsp_rdata[0], 32'h8001_7FEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_release_idle", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("bp_second_accept", 32'(busy[0]), 32'd1);
        recv(0, rd, e, lat);
        check("bp_second_rdata", rd, 32'h0000_0080);

        // Reset during WAIT aborts the store
        xfer("sw40", 0, 1'b1, 32'h40, 32'h1111_1111, ST_SW, LT_LW, 32'd0, 1'b0);
        xfer("lw40_a", 0, 1'b0, 32'h40, 32'h0, ST_SW, LT_LW, 32'h1111_1111, 1'b0);
        send(0, 1'b1, 32'h40, 32'h2222_2222, ST_SW, LT_LW);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("mid_rst_rdata", rsp_rdata[0], 32'd0);
        check("mid_rst_err", 32'(rsp_err[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        xfer("lw40_b", 0, 1'b0, 32'h40, 32'h0, ST_SW, LT_LW, 32'h1111_1111, 1'b0);

        // Zero wait states, base 0x1000, 16 words
        send(1, 1'b1, 32'h1004, 32'hA5A5_0001, ST_SW, LT_LW);
        acc_first = acc_cyc[1];
        recv(1, rd, e, lat);
        check("ws0_sw_latency", 32'(lat), 32'd1);
        check("ws0_sw_err", 32'(e), 32'd0);
        send(1, 1'b0, 32'h1004, 32'h0, ST_SW, LT_LW);
        check("ws0_period", 32'(acc_cyc[1] - acc_first), 32'd2);
        recv(1, rd, e, lat);
        check("ws0_lw_latency", 32'(lat), 32'd1);
        check("ws0_lw_rdata", rd, 32'hA5A5_0001);
        xfer("ws0_lh1006", 1, 1'b0, 32'h1006, 32'h0, ST_SW, LT_LH, 32'hFFFF_A5A5, 1'b0);
        xfer("ws0_sw_last", 1, 1'b1, 32'h103C, 32'h1234_5678, ST_SW, LT_LW, 32'd0, 1'b0);
        xfer("ws0_lw_last", 1, 1'b0, 32'h103C, 32'h0, ST_SW, LT_LW, 32'h1234_5678, 1'b0);
        xfer("ws0_below", 1, 1'b0, 32'h0FFC, 32'h0, ST_SW, LT_LW, 32'd0, 1'b1);
        xfer("ws0_above", 1, 1'b0, 32'h1040, 32'h0, ST_SW, LT_LW, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
